// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the 32-word instruction memory.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state).
module imem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] word_q, word_d;
  logic        in_ready_q, in_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        acc;
  logic        last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  assign acc  = in_valid & in_ready_q;
  assign last = ({1'b0, widx_q} == (cnt_q - 6'd1));

  // next-state, word assembly and registered output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        if (acc) begin
          cnt_d  = in_data[5:0];
          widx_d = 5'd0;
          bidx_d = 2'd0;
          if (in_data == 8'd0 || in_data > 8'd32)
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ in_data;
`endif
          bidx_d = bidx_q + 2'd1;
          word_d = {word_q[15:0], in_data};
          if (bidx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = widx_q;
            wr_data_d = {word_q, in_data};
            widx_d    = widx_q + 5'd1;
            if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (acc) state_d = (in_data == xor_q) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: begin
        if (start) state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_d == COUNT && state_q != COUNT) xor_d = 8'd0;
    in_ready_d = (state_d == COUNT) || (state_d == DATA)
               || (state_d == CHECK);
`else
    in_ready_d = (state_d == COUNT) || (state_d == DATA);
`endif
    // done waits one cycle past the final write strobe
    done_d     = (state_d == DONE) && (state_q != DATA);
    err_d      = (state_d == ERROR);
    cpu_hold_d = ~done_d;
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      widx_q     <= 5'd0;
      bidx_q     <= 2'd0;
      word_q     <= 24'd0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
// Follows IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];
  logic [31:0] img[32];
  logic [31:0] emem[32];
  logic [31:0] dmem[32];
  bit          ewr[32];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // write monitor: pops the scoreboard and mirrors the memory
  always @(negedge clk) begin
    if (reset && wr_en) begin
      dmem[wr_addr] = wr_data;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %h@%0d expected none",
                 wr_data, wr_addr);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write got %h@%0d expected %h@%0d",
                   wr_data, wr_addr, e[31:0], e[36:32]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random gaps
  task automatic send(input logic [7:0] b, input int mode);
    int  t;
    bit  a;
    int  g;
    g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
    repeat (g) cyc();
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    a = 1'b0;
    while (!a && t < 200) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got 0 expected 1");
    end
  endtask

  // sends bytes of img word i; model records the expected write
  task automatic send_word(input int i, input int mode,
                           inout logic [7:0] x);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] w;
      w = img[i];
      x ^= w[31-8*b -: 8];
      if (b == 3) begin
        exp_q.push_back({i[4:0], w});
        emem[i] = w;
        ewr[i]  = 1'b1;
      end
      send(w[31-8*b -: 8], mode);
    end
  endtask

  task automatic load(input int n, input int mode, input bit bad_sum);
    logic [7:0] x;
    x = 8'd0;
    pulse_start();
    send(n[7:0], mode);
    for (int i = 0; i < n; i++) send_word(i, mode, x);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x ^ {7'd0, bad_sum}, mode);
    chk("sum_done", {31'd0, done}, {31'd0, !bad_sum});
    chk("sum_err", {31'd0, err}, {31'd0, bad_sum});
    chk("sum_hold", {31'd0, cpu_hold}, {31'd0, bad_sum});
`else
    chk("bad_sum_unused", {31'd0, bad_sum}, 32'd0);
    chk("done_early", {31'd0, done}, 32'd0);
    cyc();
    chk("done", {31'd0, done}, 32'd1);
    chk("hold_rel", {31'd0, cpu_hold}, 32'd0);
    chk("err_clr", {31'd0, err}, 32'd0);
`endif
    chk("ready_off", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic bad_count(input logic [7:0] c);
    pulse_start();
    send(c, 0);
    cyc();
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("bad_done", {31'd0, done}, 32'd0);
    chk("bad_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ewr[i] = 1'b0;
    repeat (2) cyc();
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr", {31'd0, wr_en}, 32'd0);
    chk("rst_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    repeat (10) cyc();
    chk("idle_hold", {31'd0, cpu_hold}, 32'd1);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    img[0] = 32'h12345678;
    load(1, 0, 1'b0);

    img[0] = 32'hDEADBEEF;
    img[1] = 32'h00000020;
    load(2, 1, 1'b0);

    bad_count(8'h21);
    bad_count(8'h00);
    bad_count(8'($urandom_range(33, 255)));
    img[0] = 32'hCAFEF00D;
    load(1, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0] = 32'hAABBCCDD;
    load(1, 0, 1'b0);
    load(1, 0, 1'b1);
`endif

    for (int k = 0; k < 5; k++) begin
      int n;
      n = (k == 0) ? 32 : int'($urandom_range(1, 32));
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      load(n, k % 3, 1'b0);
    end

    // ignored start during COUNT, then a short load
    pulse_start();
    pulse_start();
    begin
      logic [7:0] x;
      x = 8'd0;
      img[0] = 32'h0BADC0DE;
      send(8'd1, 0);
      send_word(0, 0, x);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(x, 0);
`else
      cyc();
`endif
      chk("dbl_start_done", {31'd0, done}, 32'd1);
    end

    // reset mid-load after 2nd byte of word 3
    for (int i = 0; i < 32; i++) img[i] = $urandom;
    begin
      logic [7:0] x;
      x = 8'd0;
      pulse_start();
      send(8'd5, 2);
      for (int i = 0; i < 3; i++) send_word(i, 2, x);
      send(img[3][31:24], 2);
      send(img[3][23:16], 2);
    end
    reset = 1'b0;
    #2;
    chk("mid_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_wr", {31'd0, wr_en}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    cyc();
    reset = 1'b1;
    repeat (4) cyc();
    chk("post_hold", {31'd0, cpu_hold}, 32'd1);

    for (int i = 0; i < 32; i++)
      if (ewr[i]) chk($sformatf("mem%0d", i), dmem[i], emem[i]);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
